exception_controller: RTL

EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

---
 rtl/mips_pkg.sv | 18 +
 rtl/irq_pending_latch.sv | 28 ++
 rtl/exception_controller.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the exception controller: FSM encoding, cause codes
// and the default parameter values used by the controller and its IRQ latches.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_RETURN  = 2'd2
  } state_t;

  localparam logic [7:0] CAUSE_IRQ_BASE = 8'h00;
  localparam logic [7:0] CAUSE_UNDEF    = 8'h10;

  localparam int N_IRQ_DEFAULT     = 4;
  localparam int PC_W_DEFAULT      = 32;
  localparam int EDGE_MODE_DEFAULT = 1;

endpackage

// File: rtl/irq_pending_latch.sv
// One interrupt channel: captures a rising edge (or follows the level) into a
// pending bit; a fresh edge in the same cycle as a clear keeps the bit set.
module irq_pending_latch #(
  parameter int EDGE_MODE = mips_pkg::EDGE_MODE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clear,
  output logic pending
);

  logic irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      irq_q <= irq;
      if (EDGE_MODE != 0)
        pending <= (irq & ~irq_q) | (pending & ~clear);
      else
        pending <= irq;
    end
  end

endmodule

// File: rtl/exception_controller.sv
// Redirects the ID-stage instruction to an interrupt or exception handler and
// tracks handler entry/return so exactly one user instruction retires after eret.
module exception_controller
  import mips_pkg::*;
#(
  parameter int N_IRQ     = N_IRQ_DEFAULT,
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int EDGE_MODE = EDGE_MODE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             undef_instr,
  input  logic             supervised,
  input  logic             id_valid,
  input  logic             stall,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             eret,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             trap,
  output logic             trap_is_irq,
  output logic [7:0]       cause,
  output logic [PC_W-1:0]  epc,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] irq_mask
);

  state_t           state;
  logic             accept;
  logic             any_irq;
  logic             fire;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] win_oh;
  logic [N_IRQ-1:0] clear_vec;
  logic [7:0]       win_idx;

  // Lowest-index eligible IRQ wins; any IRQ outranks an undefined instruction.
  always_comb begin
    accept   = id_valid & ~stall;
    eligible = pending & ~irq_mask;
    any_irq  = |eligible;
    win_oh   = eligible & (~eligible + N_IRQ'(1));
    win_idx  = 8'h00;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) win_idx = 8'(k);
    end
    fire      = (state == ST_RUN) & accept & ~supervised & (any_irq | undef_instr);
    clear_vec = (fire & any_irq) ? win_oh : '0;
  end

  assign trap        = fire & reset;
  assign trap_is_irq = trap & any_irq;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_latch
    irq_pending_latch #(.EDGE_MODE(EDGE_MODE)) u_latch (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq[g]),
      .clear   (clear_vec[g]),
      .pending (pending[g])
    );
  end

  // The mask is written even during a stall; only trap bookkeeping freezes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      cause    <= 8'h00;
      epc      <= '0;
      irq_mask <= '0;
    end else begin
      if (mask_we) irq_mask <= mask_wdata;
      case (state)
        ST_RUN: begin
          if (fire) begin
            state <= ST_HANDLER;
            epc   <= id_pc;
            cause <= any_irq ? (CAUSE_IRQ_BASE + win_idx) : CAUSE_UNDEF;
          end
        end
        ST_HANDLER: if (accept && eret) state <= ST_RETURN;
        ST_RETURN:  if (accept) state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

endmodule
